// File: rtl/ram_initiator.sv
`default_nettype none
// ============================================================================
// Module      : ram_initiator
// Description : Single-outstanding command initiator for a strobe-driven RAM.
//               Accepts one read/write command at a time from the host.
//               Runs a fixed SETUP / STROBE / HOLD sequence so address, type
//               and data are stable one cycle either side of the single
//               ram_we rising edge. Returns one response per command.
//               Out-of-range addresses skip the RAM and respond at once with
//               rsp_err set.
// Ports       : clk, rst_n            - clock, async active-low reset
//               cmd_valid/cmd_ready   - command handshake
//               cmd_type/addr/wdata   - command payload (1 = write)
//               rsp_valid/rsp_ready   - response handshake
//               rsp_rdata/rsp_err     - response payload
//               ram_addr/we/type      - RAM address, strobe, direction
//               ram_data_in/out       - RAM write / read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_initiator #(
    parameter  int word_size     = 21,
    parameter  int word_quantity = 33,
    localparam int AW            = $clog2(word_quantity)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_type,
    input  logic [AW-1:0]        cmd_addr,
    input  logic [word_size-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [word_size-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_we,
    output logic                 ram_type,
    output logic [word_size-1:0] ram_data_in,
    input  logic [word_size-1:0] ram_data_out
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_setup  = 3'd1;
    localparam logic [2:0] c_st_strobe = 3'd2;
    localparam logic [2:0] c_st_hold   = 3'd3;
    localparam logic [2:0] c_st_resp   = 3'd4;

    // One extra bit so word_quantity itself is representable when it is a
    // power of two.
    localparam logic [AW:0] c_word_quantity = (AW+1)'(word_quantity);

    logic [2:0]           r_state;
    logic                 r_type;
    logic [AW-1:0]        r_addr;
    logic [word_size-1:0] r_wdata;
    logic [word_size-1:0] r_rdata;
    logic                 r_err;
    logic                 w_addr_ok;

    assign w_addr_ok = ({1'b0, cmd_addr} < c_word_quantity);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_type  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_type  <= cmd_type;
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_rdata <= '0;
                        if (w_addr_ok) begin
                            r_err   <= 1'b0;
                            r_state <= c_st_setup;
                        end else begin
                            // No RAM access for an out-of-range address.
                            r_err   <= 1'b1;
                            r_state <= c_st_resp;
                        end
                    end
                end
                c_st_setup:  r_state <= c_st_strobe;
                c_st_strobe: r_state <= c_st_hold;
                c_st_hold: begin
                    // RAM has had a full cycle since the strobe edge.
                    r_rdata <= r_type ? '0 : ram_data_out;
                    r_state <= c_st_resp;
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Decoded straight from the state register so that the async reset
    // removes the strobe and response immediately.
    assign cmd_ready   = (r_state == c_st_idle);
    assign ram_we      = (r_state == c_st_strobe);
    assign rsp_valid   = (r_state == c_st_resp);

    assign ram_addr    = r_addr;
    assign ram_type    = r_type;
    assign ram_data_in = r_wdata;
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_initiator
// Description : Self-checking bench for ram_initiator with a strobe RAM model
//               and a reference memory / response model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_initiator;

    localparam int WS = 21;
    localparam int WQ = 33;
    localparam int AW = $clog2(WQ);

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_type;
    logic [AW-1:0] cmd_addr;
    logic [WS-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [WS-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          ram_type;
    logic [WS-1:0] ram_data_in;
    logic [WS-1:0] ram_data_out;

    int errors = 0;
    int checks = 0;

    // RAM stand-in and reference model memory
    logic [WS-1:0] ram_mem [WQ];
    logic [WS-1:0] ref_mem [WQ];
    logic [WS-1:0] ram_rd;
    int            we_count = 0;
    logic [AW-1:0] we_addr;
    logic          we_type;

    ram_initiator #(
        .word_size    (WS),
        .word_quantity(WQ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_type    (ram_type),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    assign ram_data_out = ram_rd;

    // The RAM acts on the rising edge of its strobe.
    always @(posedge ram_we) begin
        we_count = we_count + 1;
        we_addr  = ram_addr;
        we_type  = ram_type;
        if (int'(ram_addr) < WQ) begin
            if (ram_type) ram_mem[int'(ram_addr)] = ram_data_in;
            else          ram_rd = ram_mem[int'(ram_addr)];
        end
    end

    // One full command: issue, check latency, check held response for
    // hold extra cycles with rsp_ready low, then complete it.
    task automatic do_cmd(input logic typ, input int addr, input logic [WS-1:0] data, input int hold);
        int            edges;
        int            we0;
        logic          exp_err;
        logic [WS-1:0] exp_rd;
        int            exp_lat;
        int            exp_we;
        exp_err = (addr >= WQ);
        exp_rd  = (exp_err || typ) ? '0 : ref_mem[addr];
        exp_lat = exp_err ? 1 : 4;
        exp_we  = exp_err ? 0 : 1;
        we0     = we_count;
        edges   = 0;
        while (cmd_ready !== 1'b1 && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        cmd_valid = 1'b1;
        cmd_type  = typ;
        cmd_addr  = AW'(addr);
        cmd_wdata = data;
        @(posedge clk); #1;
        // Scramble the inputs: the DUT must use its registered copy.
        cmd_valid = 1'b0;
        cmd_type  = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = WS'($urandom);
        edges = 1;
        while (rsp_valid !== 1'b1 && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        checks++;
        if (edges !== exp_lat) begin
            errors++;
            $display("FAIL latency addr=%0d: got %0d cycles, expected %0d", addr, edges, exp_lat);
        end
        if (!exp_err && typ) ref_mem[addr] = data;
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if ({rsp_valid, rsp_err, rsp_rdata, cmd_ready} !== {1'b1, exp_err, exp_rd, 1'b0}) begin
                errors++;
                $display("FAIL response addr=%0d cyc=%0d: got v=%b e=%b d=%h rdy=%b, expected v=1 e=%b d=%h rdy=0",
                         addr, i, rsp_valid, rsp_err, rsp_rdata, cmd_ready, exp_err, exp_rd);
            end
            checks++;
            if ({ram_type, ram_addr, ram_data_in} !== {typ, AW'(addr), data}) begin
                errors++;
                $display("FAIL ram_hold addr=%0d: got t=%b a=%0d d=%h, expected t=%b a=%0d d=%h",
                         addr, ram_type, ram_addr, ram_data_in, typ, addr, data);
            end
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL return_idle addr=%0d: got v=%b rdy=%b, expected v=0 rdy=1", addr, rsp_valid, cmd_ready);
        end
        checks++;
        if (we_count - we0 !== exp_we) begin
            errors++;
            $display("FAIL we_pulses addr=%0d: got %0d, expected %0d", addr, we_count - we0, exp_we);
        end
        if (!exp_err) begin
            checks++;
            if (we_addr !== AW'(addr) || we_type !== typ) begin
                errors++;
                $display("FAIL strobe_payload: got a=%0d t=%b, expected a=%0d t=%b", we_addr, we_type, addr, typ);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_rdata, ram_we, ram_type, ram_addr, ram_data_in} !==
            {1'b1, 1'b0, 1'b0, {WS{1'b0}}, 1'b0, 1'b0, {AW{1'b0}}, {WS{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b e=%b d=%h we=%b t=%b a=%0d wd=%h, expected rdy=1 rest 0",
                     cmd_ready, rsp_valid, rsp_err, rsp_rdata, ram_we, ram_type, ram_addr, ram_data_in);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Accepted on the first rising edge after release.
        do_cmd(1'b1, 5, 21'h1ABCDE, 0);
    endtask

    task automatic test_write_read();
        do_cmd(1'b1, 5, 21'h1ABCDE, 0);
        do_cmd(1'b0, 5, 21'h000000, 0);
        do_cmd(1'b1, 0, 21'h15A5A5, 1);
        do_cmd(1'b0, 0, 21'h0F0F0F, 0);
    endtask

    task automatic test_error();
        do_cmd(1'b0, 33, 21'h123456, 0);
        do_cmd(1'b1, 40, 21'h0ABCDE, 2);
        do_cmd(1'b0, 32, 21'h000001, 0);
    endtask

    task automatic test_resp_hold();
        do_cmd(1'b0, 5, 21'h1FFFFF, 5);
        do_cmd(1'b1, 12, 21'h0C0FFE, 5);
    endtask

    task automatic test_reset_in_strobe();
        int edges;
        int seen;
        cmd_valid = 1'b1;
        cmd_type  = 1'b0;
        cmd_addr  = AW'(7);
        cmd_wdata = WS'($urandom);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        edges = 0;
        while (ram_we !== 1'b1 && edges < 10) begin
            @(posedge clk); #1; edges++;
        end
        checks++;
        if (edges !== 1) begin
            errors++;
            $display("FAIL strobe_timing: got %0d cycles after accept, expected 1", edges);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_we, cmd_ready, rsp_valid, ram_addr, ram_type} !== {1'b0, 1'b1, 1'b0, {AW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got we=%b rdy=%b v=%b a=%0d t=%b, expected we=0 rdy=1 v=0 a=0 t=0",
                     ram_we, cmd_ready, rsp_valid, ram_addr, ram_type);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL discarded_rsp: got %0d response cycles, expected 0", seen);
        end
        do_cmd(1'b1, 9, 21'h0BEEF1, 0);
        do_cmd(1'b0, 9, 21'h000000, 0);
    endtask

    task automatic test_back_to_back();
        int            edges;
        int            we0;
        logic [WS-1:0] d0;
        logic [WS-1:0] d1;
        d0 = WS'($urandom);
        d1 = WS'($urandom);
        we0 = we_count;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_type  = 1'b1;
        cmd_addr  = AW'(0);
        cmd_wdata = d0;
        @(posedge clk); #1;
        cmd_addr  = AW'(32);
        cmd_wdata = d1;
        edges = 1;
        while (rsp_valid !== 1'b1 && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        checks++;
        if (edges !== 4 || ram_addr !== AW'(0) || ram_data_in !== d0) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d a=%0d d=%h, expected lat=4 a=0 d=%h", edges, ram_addr, ram_data_in, d0);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_addr !== AW'(0)) begin
            errors++;
            $display("FAIL b2b_idle_gap: got rdy=%b v=%b a=%0d, expected rdy=1 v=0 a=0", cmd_ready, rsp_valid, ram_addr);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || ram_addr !== AW'(32) || ram_data_in !== d1) begin
            errors++;
            $display("FAIL b2b_second_accept: got rdy=%b a=%0d d=%h, expected rdy=0 a=32 d=%h", cmd_ready, ram_addr, ram_data_in, d1);
        end
        edges = 1;
        while (rsp_valid !== 1'b1 && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        checks++;
        if (edges !== 4 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL b2b_second_rsp: got lat=%0d e=%b d=%h, expected lat=4 e=0 d=0", edges, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (we_count - we0 !== 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d, expected 2", we_count - we0);
        end
        ref_mem[0]  = d0;
        ref_mem[32] = d1;
        do_cmd(1'b0, 0, 21'h000000, 0);
        do_cmd(1'b0, 32, 21'h000000, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            do_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
                   WS'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < WQ; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_rd    = '0;
        clk       = 1'b0;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_error();
        test_resp_hold();
        test_reset_in_strobe();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_initiator.md
RAM_INITIATOR -- requirements
Module: ram_initiator

Interface
REQ-001 SHALL have parameter word_size, default 21, RAM word width in bits.
REQ-002 SHALL have parameter word_quantity, default 33, number of RAM words; AW = $clog2(word_quantity).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  host command present.
REQ-006 SHALL have port cmd_ready  output  1  initiator can accept a command.
REQ-007 SHALL have port cmd_type  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr  input  AW  target word address.
REQ-009 SHALL have port cmd_wdata  input  word_size  write data.
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  host accepts response.
REQ-012 SHALL have port rsp_rdata  output  word_size  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err  output  1  address out of range, no RAM access made.
REQ-014 SHALL have port ram_addr  output  AW  RAM address.
REQ-015 SHALL have port ram_we  output  1  RAM access strobe; the RAM acts on its rising edge.
REQ-016 SHALL have port ram_type  output  1  1 = write, 0 = read.
REQ-017 SHALL have port ram_data_in  output  word_size  data to RAM.
REQ-018 SHALL have port ram_data_out  input  word_size  data from RAM.

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD, RESP.
REQ-020 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready on a clock edge.
REQ-021 SHALL register cmd_type, cmd_addr and cmd_wdata on acceptance and hold them unchanged on ram_type, ram_addr and ram_data_in until the next acceptance.
REQ-022 SHALL, on acceptance with cmd_addr <= word_quantity-1, transition IDLE->SETUP->STROBE->HOLD->RESP, one cycle each.
REQ-023 SHALL drive ram_we = 1 only in STROBE, giving exactly one rising edge per valid command with addr, type and data stable one cycle before and after it.
REQ-024 SHALL, for a read, capture ram_data_out into rsp_rdata on the HOLD->RESP edge.
REQ-025 SHALL, on acceptance with cmd_addr >= word_quantity, go IDLE->RESP directly with rsp_err = 1, rsp_rdata = 0 and no ram_we pulse.
REQ-026 SHALL assert rsp_valid only in RESP; latency from the acceptance edge to rsp_valid is 4 cycles for valid addresses and 1 cycle for errors.
REQ-027 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge.
REQ-028 SHALL ignore cmd_valid outside IDLE; back-to-back commands are separated by at least the RESP->IDLE cycle.
REQ-029 SHALL process a write response with rsp_rdata = 0 and rsp_err = 0.

Reset
REQ-030 SHALL, while rst_n = 0, force state IDLE, cmd_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, ram_we = 0, ram_type = 0, ram_addr = 0 and ram_data_in = 0, asynchronously.
REQ-031 SHALL, on reset asserted in STROBE, drop ram_we immediately, discard the transaction and issue no response.
REQ-032 SHALL accept a command on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL cover: write addr 5 data 0x1ABCDE -> exactly one ram_we pulse with ram_addr = 5, ram_type = 1; rsp_valid 4 cycles after acceptance, rsp_err = 0, rsp_rdata = 0.
REQ-034 SHALL cover: write then read addr 5 against a RAM model -> read response rsp_rdata = 0x1ABCDE.
REQ-035 SHALL cover: read addr 33 with word_quantity = 33 -> no ram_we edge; rsp_valid 1 cycle after acceptance, rsp_err = 1, rsp_rdata = 0.
REQ-036 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable and cmd_ready = 0 throughout; IDLE on the cycle after rsp_ready = 1.
REQ-037 SHALL cover: rst_n pulled low during STROBE -> ram_we = 0 with no clock edge; no rsp_valid; the next command completes normally.
REQ-038 SHALL cover: writes to addr 0 and addr 32 with back-to-back cmd_valid -> both complete, one ram_we pulse each, the second accepted only in IDLE.
